// File: rtl/enum_seq_ctrl_pkg.sv
// Shared types for the enumerated element sequencer: element, gap and phase enums
// plus small arithmetic helpers used by the controller and its dwell counter.
package enum_seq_pkg;

    typedef enum int {H = 0, He, Li, Be, B, C, N} elem_t;
    typedef enum bit [2:0] {A0 = 3'd0, A1 = 3'd1, A2 = 3'd2, A3 = 3'd3, A4 = 3'd4} gap_t;
    typedef enum logic [1:0] {zero = 2'd0, one = 2'd1, two = 2'd2, three = 2'd3} phase_t;

    localparam elem_t ELEM_LAST = N;

    function automatic gap_t gap_of(input logic [2:0] cnt);
        return (cnt >= 3'd4) ? A4 : gap_t'(cnt);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/enum_seq_ctrl_if.sv
// Handshake and status bundle between the sequencer (master) and its consumer (slave).
interface enum_seq_ctrl_if;
    import enum_seq_pkg::*;

    logic        start;
    logic        abort;
    logic        elem_rdy;
    elem_t       elem;
    logic        elem_vld;
    gap_t        gap;
    phase_t      phase;
    logic        busy;
    logic        done;
    logic [7:0]  xfer_cnt;

    modport master (
        input  start, abort, elem_rdy,
        output elem, elem_vld, gap, phase, busy, done, xfer_cnt
    );

    modport slave (
        output start, abort, elem_rdy,
        input  elem, elem_vld, gap, phase, busy, done, xfer_cnt
    );

endinterface

// File: rtl/enum_seq_dwell.sv
// Loadable dwell down-counter; reports zero/one flags and a saturated gap_t view.
module enum_seq_dwell
    import enum_seq_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    output logic is_zero,
    output logic is_one,
    output gap_t gap
);

    localparam logic [2:0] RELOAD = 3'(DWELL - 1);

    logic [2:0] cnt_r;

    // Counter register: clear wins over load, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 3'd0;
        end else if (clr) begin
            cnt_r <= 3'd0;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign is_zero = (cnt_r == 3'd0);
    assign is_one  = (cnt_r == 3'd1);
    assign gap     = gap_of(cnt_r);

endmodule

// File: rtl/enum_seq_ctrl.sv
// Sequencer that streams elem_t values H.. over valid/ready with an optional dwell
// gap between elements, optional looping, and a phase_t view of its FSM.
module enum_seq_ctrl
    import enum_seq_pkg::*;
#(
    parameter int NUM_ELEM = 7,
    parameter int DWELL    = 1,
    parameter int LOOP     = 0
) (
    input  logic             clk,
    input  logic             rst,
    enum_seq_ctrl_if.master  bus
);

    localparam elem_t LAST = (NUM_ELEM - 1 > int'(ELEM_LAST)) ? ELEM_LAST : elem_t'(NUM_ELEM - 1);
    localparam logic  B2B  = logic'(DWELL == 1);

    phase_t      phase_r, phase_s;
    elem_t       elem_r, elem_s;
    logic        vld_r, vld_s;
    logic        done_r, done_s;
    logic [7:0]  xfer_r, xfer_s;
    logic        load_s, clr_s, hs_s;
    logic        is_zero_s, is_one_s;
    gap_t        gap_s;

    enum_seq_dwell #(.DWELL(DWELL)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .clr     (clr_s),
        .is_zero (is_zero_s),
        .is_one  (is_one_s),
        .gap     (gap_s)
    );

    // Next-state and next-output decode; abort outside IDLE overrides the phase logic.
    always_comb begin
        phase_s = phase_r;
        elem_s  = elem_r;
        vld_s   = vld_r;
        done_s  = 1'b0;
        xfer_s  = xfer_r;
        load_s  = 1'b0;
        clr_s   = 1'b0;
        hs_s    = vld_r & bus.elem_rdy;

        if ((phase_r != zero) && bus.abort) begin
            phase_s = zero;
            vld_s   = 1'b0;
            clr_s   = 1'b1;
            xfer_s  = hs_s ? sat_inc8(xfer_r) : xfer_r;
        end else begin
            case (phase_r)
                zero: begin
                    if (bus.start && !bus.abort) begin
                        phase_s = one;
                        xfer_s  = 8'd0;
                    end else begin
                        phase_s = zero;
                    end
                end
                one: begin
                    phase_s = two;
                    elem_s  = H;
                    vld_s   = 1'b1;
                    clr_s   = 1'b1;
                end
                two: begin
                    if (hs_s) begin
                        xfer_s = sat_inc8(xfer_r);
                        if ((elem_r == LAST) && (LOOP == 0)) begin
                            phase_s = three;
                            vld_s   = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            elem_s = (elem_r == LAST) ? H : elem_t'(int'(elem_r) + 1);
                            load_s = 1'b1;
                            vld_s  = B2B;
                        end
                    end else if (!vld_r) begin
                        // Valid rises on the edge where the dwell counter reaches zero.
                        vld_s = is_one_s | is_zero_s;
                    end else begin
                        vld_s = 1'b1;
                    end
                end
                three: begin
                    phase_s = zero;
                end
                default: begin
                    phase_s = zero;
                    vld_s   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= zero;
            elem_r  <= H;
            vld_r   <= 1'b0;
            done_r  <= 1'b0;
            xfer_r  <= 8'd0;
        end else begin
            phase_r <= phase_s;
            elem_r  <= elem_s;
            vld_r   <= vld_s;
            done_r  <= done_s;
            xfer_r  <= xfer_s;
        end
    end

    assign bus.elem     = elem_r;
    assign bus.elem_vld = vld_r;
    assign bus.gap      = gap_s;
    assign bus.phase    = phase_r;
    assign bus.busy     = (phase_r != zero);
    assign bus.done     = done_r;
    assign bus.xfer_cnt = xfer_r;

endmodule

// File: tb/tb_enum_seq_ctrl.sv
// Randomized and directed bench for enum_seq_ctrl: three configurations run side by side
// against an abstract per-cycle model (remaining-dwell count, element index, handshake count).
module tb_enum_seq_ctrl;
    import enum_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    enum_seq_ctrl_if if0 ();
    enum_seq_ctrl_if if1 ();
    enum_seq_ctrl_if if2 ();

    enum_seq_ctrl #(.NUM_ELEM(7), .DWELL(1), .LOOP(0)) u_def  (.clk(clk), .rst(rst), .bus(if0));
    enum_seq_ctrl #(.NUM_ELEM(7), .DWELL(3), .LOOP(0)) u_dw   (.clk(clk), .rst(rst), .bus(if1));
    enum_seq_ctrl #(.NUM_ELEM(3), .DWELL(1), .LOOP(1)) u_loop (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        int phase;
        int elem;
        int rem;
        int xfer;
    } m_t;

    m_t m [3];

    function automatic m_t m_reset();
        m_t r;
        r.phase = 0; r.elem = 0; r.rem = 0; r.xfer = 0;
        return r;
    endfunction

    function automatic m_t step(m_t s, int ne, int dw, int lp, logic st, logic ab, logic rd);
        m_t n;
        bit hs;
        n  = s;
        hs = (s.phase == 2) && (s.rem == 0) && (rd === 1'b1);
        if (s.phase == 0) begin
            if (st === 1'b1 && ab !== 1'b1) begin
                n.phase = 1;
                n.xfer  = 0;
            end
        end else if (ab === 1'b1) begin
            n.phase = 0;
            n.rem   = 0;
            if (hs) n.xfer = (s.xfer < 255) ? s.xfer + 1 : 255;
        end else if (s.phase == 1) begin
            n.phase = 2;
            n.elem  = 0;
            n.rem   = 0;
        end else if (s.phase == 2) begin
            if (hs) begin
                n.xfer = (s.xfer < 255) ? s.xfer + 1 : 255;
                if (s.elem == ne - 1 && lp == 0) begin
                    n.phase = 3;
                end else begin
                    n.elem = (s.elem + 1) % ne;
                    n.rem  = dw - 1;
                end
            end else if (s.rem > 0) begin
                n.rem = s.rem - 1;
            end
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= m_reset();
            m[1] <= m_reset();
            m[2] <= m_reset();
        end else begin
            m[0] <= step(m[0], 7, 1, 0, if0.start, if0.abort, if0.elem_rdy);
            m[1] <= step(m[1], 7, 3, 0, if1.start, if1.abort, if1.elem_rdy);
            m[2] <= step(m[2], 3, 1, 1, if2.start, if2.abort, if2.elem_rdy);
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input int k, input m_t s, input logic [31:0] el, input logic vld,
                           input logic [2:0] gp, input logic [1:0] ph, input logic bz,
                           input logic dn, input logic [7:0] xf);
        chk("phase", k, 32'(ph), 32'(s.phase));
        chk("elem_vld", k, 32'(vld), 32'((s.phase == 2 && s.rem == 0) ? 1 : 0));
        chk("gap", k, 32'(gp), 32'((s.rem > 4) ? 4 : s.rem));
        chk("busy", k, 32'(bz), 32'((s.phase != 0) ? 1 : 0));
        chk("done", k, 32'(dn), 32'((s.phase == 3) ? 1 : 0));
        chk("xfer_cnt", k, 32'(xf), 32'(s.xfer));
        chk("elem", k, el, 32'(s.elem));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_one(0, m[0], 32'(if0.elem), if0.elem_vld, 3'(if0.gap), 2'(if0.phase), if0.busy, if0.done, if0.xfer_cnt);
            cmp_one(1, m[1], 32'(if1.elem), if1.elem_vld, 3'(if1.gap), 2'(if1.phase), if1.busy, if1.done, if1.xfer_cnt);
            cmp_one(2, m[2], 32'(if2.elem), if2.elem_vld, 3'(if2.gap), 2'(if2.phase), if2.busy, if2.done, if2.xfer_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;
        if0.start = 1'b0; if0.abort = 1'b0; if0.elem_rdy = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.elem_rdy = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0; if2.elem_rdy = 1'b0;

        tick();
        chk_en = 1'b1;
        chk("rst_phase", 0, 32'(if0.phase), 32'd0);
        chk("rst_xfer", 0, 32'(if0.xfer_cnt), 32'd0);
        ticks(2);
        @(negedge clk); #2; rst = 1'b0;

        // All three configurations start together with the consumer always ready.
        tick();
        if0.start = 1'b1; if1.start = 1'b1; if2.start = 1'b1;
        if0.elem_rdy = 1'b1; if1.elem_rdy = 1'b1; if2.elem_rdy = 1'b1;
        tick();
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        chk("A_load_phase", 0, 32'(if0.phase), 32'd1);
        chk("A_load_vld", 0, 32'(if0.elem_vld), 32'd0);
        tick();
        chk("A_first_vld", 0, 32'(if0.elem_vld), 32'd1);
        chk("A_first_elem", 0, 32'(if0.elem), 32'd0);
        chk("A_dw_first_vld", 1, 32'(if1.elem_vld), 32'd1);
        tick();
        chk("A_dw_bubble_vld", 1, 32'(if1.elem_vld), 32'd0);
        chk("A_dw_gap2", 1, 32'(if1.gap), 32'd2);
        tick();
        chk("A_dw_gap1", 1, 32'(if1.gap), 32'd1);
        tick();
        chk("A_dw_second", 1, 32'(if1.elem), 32'd1);
        chk("A_dw_second_vld", 1, 32'(if1.elem_vld), 32'd1);
        ticks(3);
        chk("A_last_elem", 0, 32'(if0.elem), 32'd6);
        tick();
        chk("A_done", 0, 32'(if0.done), 32'd1);
        chk("A_xfer7", 0, 32'(if0.xfer_cnt), 32'd7);
        chk("A_finish_elem", 0, 32'(if0.elem), 32'd6);
        tick();
        chk("A_idle", 0, 32'(if0.phase), 32'd0);
        chk("A_done_gone", 0, 32'(if0.done), 32'd0);
        ticks(11);
        chk("A_dw_done", 1, 32'(if1.done), 32'd1);
        chk("A_dw_xfer7", 1, 32'(if1.xfer_cnt), 32'd7);
        if2.abort = 1'b1;
        tick();
        if2.abort = 1'b0;
        chk("A_loop_abort", 2, 32'(if2.phase), 32'd0);

        // Back-pressure on Li, then abort while B is offered.
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (if0.elem_vld === 1'b1 && if0.elem == Li) found = 1'b1;
        end
        chk("B_found_li", 0, 32'(found), 32'd1);
        if0.elem_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("B_hold_elem", 0, 32'(if0.elem), 32'd2);
            chk("B_hold_vld", 0, 32'(if0.elem_vld), 32'd1);
        end
        if0.elem_rdy = 1'b1;
        tick();
        chk("B_adv_be", 0, 32'(if0.elem), 32'd3);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (if0.elem_vld === 1'b1 && if0.elem == B) found = 1'b1;
            else tick();
        end
        chk("B_found_b", 0, 32'(found), 32'd1);
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        chk("B_abort_phase", 0, 32'(if0.phase), 32'd0);
        chk("B_abort_vld", 0, 32'(if0.elem_vld), 32'd0);
        chk("B_abort_xfer", 0, 32'(if0.xfer_cnt), 32'd5);
        chk("B_abort_nodone", 0, 32'(if0.done), 32'd0);

        // Looping run long enough to saturate the handshake counter.
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        ticks(300);
        chk("C_sat255", 2, 32'(if2.xfer_cnt), 32'd255);
        if2.abort = 1'b1;
        tick();
        if2.abort = 1'b0;

        // Random traffic on all three instances.
        for (int i = 0; i < 2000; i++) begin
            if0.elem_rdy = ($urandom_range(0, 3) != 0);
            if1.elem_rdy = ($urandom_range(0, 3) != 0);
            if2.elem_rdy = ($urandom_range(0, 3) != 0);
            if0.start = ($urandom_range(0, 7) == 0);
            if1.start = ($urandom_range(0, 7) == 0);
            if2.start = ($urandom_range(0, 7) == 0);
            if0.abort = ($urandom_range(0, 40) == 0);
            if1.abort = ($urandom_range(0, 40) == 0);
            if2.abort = ($urandom_range(0, 60) == 0);
            tick();
        end
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
        if0.abort = 1'b1; if1.abort = 1'b1; if2.abort = 1'b1;
        tick();
        if0.abort = 1'b0; if1.abort = 1'b0; if2.abort = 1'b0;
        if0.elem_rdy = 1'b1;

        // Asynchronous reset in the middle of EMIT, then a clean restart.
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        ticks(3);
        @(negedge clk); #2; rst = 1'b1;
        #1;
        chk("E_async_phase", 0, 32'(if0.phase), 32'd0);
        chk("E_async_vld", 0, 32'(if0.elem_vld), 32'd0);
        @(negedge clk); #2; rst = 1'b0;
        tick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        tick();
        chk("E_restart_vld", 0, 32'(if0.elem_vld), 32'd1);
        chk("E_restart_h", 0, 32'(if0.elem), 32'd0);
        ticks(12);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enum_seq_ctrl.md
Name: enum_seq_ctrl

Overview:
Controller that sequences an int-based enumerated element stream (H, He, Li, Be, B, C, N) to a downstream consumer over a valid/ready handshake.
- Inserts a configurable dwell gap between elements; optional looping.
- Exposes its FSM state as a 2-bit logic-enum phase.
- Sits between the test/stimulus top and any consumer of enumerated values; makes int, bit and logic enums change under real sequential control for waveform inspection.

Parameters:
- NUM_ELEM, 7, number of element values emitted per run (1..7; values 0..NUM_ELEM-1 = H..).
- DWELL, 1, cycles from one accepted element to the next valid element (1..8; 1 = back-to-back).
- LOOP, 0, 1 = wrap to H after last element and keep running until abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in phase zero.
- abort  in  1  terminate run; returns to phase zero next cycle.
- elem  out  32  current element, int enum elem_t (H=0 .. N=6).
- elem_vld  out  1  elem valid.
- elem_rdy  in  1  consumer ready.
- gap  out  3  bit enum gap_t (A0..A4) showing remaining dwell, saturated at A4.
- phase  out  2  logic enum phase_t: zero=IDLE, one=LOAD, two=EMIT, three=FINISH.
- busy  out  1  phase != zero.
- done  out  1  one-cycle pulse in FINISH.
- xfer_cnt  out  8  handshakes completed in current/last run, saturating at 255.

Behaviour:
- Reset (async assert, sync-released use): phase=zero, elem=H, elem_vld=0, gap=A0, busy=0, done=0, xfer_cnt=0.
- IDLE (zero): start=1 and abort=0 -> LOAD next cycle, xfer_cnt cleared. Simultaneous start and abort -> stay IDLE.
- LOAD (one): exactly 1 cycle. elem=H, dwell counter=0 -> EMIT. elem_vld stays 0 in LOAD. First elem_vld=1 is 2 cycles after start sampled.
- EMIT (two): while dwell counter=0, elem_vld=1 and elem is held stable until elem_vld&elem_rdy. Valid never drops without a handshake, except on abort.
- On handshake:
  - xfer_cnt++ (saturating at 255).
  - If elem==NUM_ELEM-1 and LOOP=0 -> FINISH, elem_vld=0.
  - If elem==NUM_ELEM-1 and LOOP=1 -> elem=H.
  - Otherwise elem++.
  - Dwell counter loads DWELL-1. While the counter is nonzero, elem_vld=0; the counter decrements each cycle.
  - DWELL=1 gives back-to-back valid with no bubble.
- gap output = min(dwell counter, 4) as gap_t.
- FINISH (three): done=1 for exactly 1 cycle -> IDLE. elem holds its last value. xfer_cnt holds until the next start.
- abort=1 in LOAD/EMIT/FINISH -> IDLE next cycle: elem_vld=0, gap=A0, no done pulse. A handshake coinciding with abort still counts in xfer_cnt.
- start while busy is ignored.
- elem_rdy is don't-care when elem_vld=0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package enum_seq_pkg holds:
  - typedef enum int {H, He, Li, Be, B, C, N} elem_t;
  - typedef enum bit [2:0] {A0..A4} gap_t;
  - typedef enum logic [1:0] {zero, one, two, three} phase_t;
  - localparam ELEM_LAST = N.
- One sub-module, enum_seq_dwell:
  - Loadable down-counter with zero flag and saturated gap_t view.
  - Parameterized by DWELL.

Test Plan:
1. Defaults, elem_rdy=1, start pulse at cycle 4 -> LOAD at cycle 5; elem H..N valid on cycles 6..12 back-to-back; done pulse at cycle 13; xfer_cnt=7; phase back to zero at cycle 14.
2. DWELL=3, elem_rdy=1 -> every handshake is followed by 2 cycles with elem_vld=0 and gap=A2 then A1; 7 elements span 19 cycles.
3. elem_rdy held 0 for 5 cycles while elem=Li valid -> elem stays Li and elem_vld stays 1 throughout; advances to Be the cycle after elem_rdy=1.
4. abort asserted while elem=B, elem_rdy=1 -> next cycle phase=zero, elem_vld=0, done never pulses, xfer_cnt=5.
5. LOOP=1, NUM_ELEM=3 -> elem sequence H, He, Li, H, He...; done never asserts; xfer_cnt saturates at 255 after 255 handshakes.
6. rst asserted asynchronously mid-EMIT (between clock edges) -> phase=zero and elem_vld=0 immediately; a start after release restarts at H.
